// File: rtl/pc_unit_pkg.sv
// Shared constants, state encoding and helpers for the program-counter stage.
package pc_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  localparam logic [XLEN-1:0] ZERO_WORD        = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_S_WAIT = 2'd0,
    PC_S_INIT = 2'd1,
    PC_S_RUN  = 2'd2,
    PC_S_HALT = 2'd3
  } pc_state_e;

  // Instruction addresses are word aligned; low two bits of any target are dropped.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_unit_next_sel.sv
// Combinational next-PC selection: jr > jump > branch > pc+4, with target alignment.
module pc_next_sel
  import pc_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4
);

  // Wraps modulo 2^32 by construction.
  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    next_pc = ZERO_WORD;
    if (jr) begin
      next_pc = align_word(jr_target);
    end else if (jump) begin
      next_pc = align_word(jump_target);
    end else if (branch_taken) begin
      next_pc = align_word(branch_target);
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: start-up sequencing after program upload, PC register, halt/stall.
// Optional PC bounds check enabled by defining PC_BOUNDS_CHECK_EN.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = DEFAULT_RESET_PC,
  parameter int unsigned INIT_CYCLES   = 2,
  parameter int unsigned ROM_ADDR_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upg_rst_i,
  input  logic        upg_done_i,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        halt_req,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        inited,
  output logic        halted,
  output logic        fault
);

`ifdef PC_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);

  pc_state_e        state;
  logic [CNT_W-1:0] count;
  logic [31:0]      next_pc;
  logic             kickoff;
  logic             out_of_range;
  logic             fault_q;

  // Same CPU-mode qualifier that fetch uses; low means an upload is in progress.
  assign kickoff      = upg_rst_i | upg_done_i;
  assign out_of_range = |(next_pc >> ROM_ADDR_BITS);
  assign fault        = fault_q;

  pc_next_sel u_next_sel (
    .pc            (pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_target     (jr_target),
    .next_pc       (next_pc),
    .pc_plus4      (pc_plus4)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= PC_S_WAIT;
      pc      <= RESET_PC;
      count   <= '0;
      inited  <= 1'b0;
      halted  <= 1'b0;
      fault_q <= 1'b0;
    end else if (!kickoff) begin
      // A new upload restarts the stage regardless of any other input.
      state   <= PC_S_WAIT;
      pc      <= RESET_PC;
      count   <= '0;
      inited  <= 1'b0;
      halted  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      unique case (state)
        PC_S_WAIT: begin
          state <= PC_S_INIT;
          count <= '0;
        end
        PC_S_INIT: begin
          pc    <= RESET_PC;
          count <= count + CNT_W'(1);
          if (count == INIT_LAST) begin
            state  <= PC_S_RUN;
            inited <= 1'b1;
          end
        end
        PC_S_RUN: begin
          if (halt_req) begin
            state  <= PC_S_HALT;
            halted <= 1'b1;
          end else if (stall) begin
            pc <= pc;
          end else if (BOUNDS_EN && out_of_range) begin
            state   <= PC_S_HALT;
            halted  <= 1'b1;
            fault_q <= 1'b1;
          end else begin
            pc <= next_pc;
          end
        end
        PC_S_HALT: begin
          pc <= pc;
        end
        default: begin
          state <= PC_S_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit; expected values are hand-computed.
`timescale 1ns/1ps
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        upg_rst_i, upg_done_i, stall, branch_taken, jump, jr, halt_req;
  logic [31:0] branch_target, jump_target, jr_target;
  logic [31:0] pc, pc_plus4;
  logic        inited, halted, fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk           (clk),
    .rst           (rst),
    .upg_rst_i     (upg_rst_i),
    .upg_done_i    (upg_done_i),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_target     (jr_target),
    .halt_req      (halt_req),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .inited        (inited),
    .halted        (halted),
    .fault         (fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirects();
    branch_taken = 1'b0; jump = 1'b0; jr = 1'b0;
    halt_req = 1'b0; stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1; upg_rst_i = 1'b0; upg_done_i = 1'b0;
    branch_target = '0; jump_target = '0; jr_target = '0;
    clear_redirects();
    tick(); tick();
    rst = 1'b0;
    check("rst_pc", pc, 32'h0);
    check("rst_inited", 32'(inited), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    tick();
    check("wait_hold_pc", pc, 32'h0);
    check("wait_inited", 32'(inited), 32'h0);

    // Start-up: two INIT clocks then RUN.
    upg_rst_i = 1'b1;
    tick(); check("init1_inited", 32'(inited), 32'h0); check("init1_pc", pc, 32'h0);
    tick(); check("init2_inited", 32'(inited), 32'h0);
    tick(); check("run_inited", 32'(inited), 32'h1); check("run_pc0", pc, 32'h0);
    check("run_plus4", pc_plus4, 32'h4);
    tick(); check("seq_pc4", pc, 32'h4);
    tick(); check("seq_pc8", pc, 32'h8);
    tick(); check("seq_pc12", pc, 32'hC);
    tick(); check("seq_pc16", pc, 32'h10);

    // Priority: jr wins over jump and branch.
    jr = 1'b1; jr_target = 32'h200;
    jump = 1'b1; jump_target = 32'h300;
    branch_taken = 1'b1; branch_target = 32'h400;
    tick(); check("prio_jr", pc, 32'h200);
    jr = 1'b0; jump = 1'b0; branch_target = 32'h403;
    tick(); check("branch_align", pc, 32'h400);
    branch_taken = 1'b0;
    jump = 1'b1; jump_target = 32'h1C;
    tick(); check("jump_1c", pc, 32'h1C);
    jump = 1'b0;
    tick(); check("seq_20", pc, 32'h20);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); check("stall_hold", pc, 32'h20);
    end
    halt_req = 1'b1; jump = 1'b1; jump_target = 32'h300;
    tick();
    check("halt_halted", 32'(halted), 32'h1);
    check("halt_pc", pc, 32'h20);
    check("halt_inited", 32'(inited), 32'h1);
    halt_req = 1'b0; stall = 1'b0;
    tick(); check("halt_frozen", pc, 32'h20);
    clear_redirects();

    // Upload restart from HALT.
    upg_rst_i = 1'b0; upg_done_i = 1'b0;
    tick();
    check("restart_pc", pc, 32'h0);
    check("restart_inited", 32'(inited), 32'h0);
    check("restart_halted", 32'(halted), 32'h0);
    upg_done_i = 1'b1; stall = 1'b1;
    tick(); tick(); check("rerun_wait_inited", 32'(inited), 32'h0);
    tick(); check("rerun_inited", 32'(inited), 32'h1); check("rerun_pc", pc, 32'h0);
    stall = 1'b0;
    tick(); check("rerun_pc4", pc, 32'h4);

`ifdef PC_BOUNDS_CHECK_EN
    jump = 1'b1; jump_target = 32'h0001_0000;
    tick();
    check("oob_pc", pc, 32'h4);
    check("oob_halted", 32'(halted), 32'h1);
    check("oob_fault", 32'(fault), 32'h1);
    jump = 1'b0;
`else
    jump = 1'b1; jump_target = 32'hFFFF_FFFF;
    tick();
    check("wrap_top", pc, 32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4, 32'h0);
    check("nofault", 32'(fault), 32'h0);
    jump = 1'b0;
    tick(); check("wrap_zero", pc, 32'h0);
    jump = 1'b1; jump_target = 32'h0001_0000;
    tick(); check("upper_pass", pc, 32'h0001_0000);
    jump = 1'b0;
    tick(); check("upper_seq", pc, 32'h0001_0004);
`endif

    // Asynchronous reset between edges.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_pc", pc, 32'h0);
    check("async_inited", 32'(inited), 32'h0);
    check("async_halted", 32'(halted), 32'h0);
    check("async_fault", 32'(fault), 32'h0);
    #2 rst = 1'b0;
    tick(); check("post_rst_inited", 32'(inited), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
